// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues PC addresses to instruction memory with one access
// outstanding, buffers returned words in a small prefetch FIFO and feeds decode.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int IW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] fetch_pc,
  output logic          fetch_stall,
  output logic          pc_take,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [IW-1:0] dec_instr,
  output logic [AW-1:0] dec_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_DATA, DISCARD} state_t;

  state_t              state_reg, state_next;
  logic [AW-1:0]       addr_reg, addr_next;
  logic [CW-1:0]       count_reg, count_next;
  logic [PW-1:0]       wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]       rd_ptr_reg, rd_ptr_next;
  logic [IW+AW-1:0]    entry_mem [DEPTH];
  logic [IW+AW-1:0]    head;

  logic inflight;
  logic space;
  logic issue_new;
  logic push;
  logic pop;

  // A new address can be taken from fetch_pc when idle, or when the outstanding
  // response completes this cycle (back-to-back fetch).
  always_comb begin
    inflight  = (state_reg == WAIT_GNT) || (state_reg == WAIT_DATA);
    space     = (int'(count_reg) + int'(inflight)) < DEPTH;
    issue_new = reset && !flush && space &&
                ((state_reg == IDLE) || ((state_reg == WAIT_DATA) && imem_rvalid));
    push      = (state_reg == WAIT_DATA) && imem_rvalid && !flush;
    pop       = dec_valid && dec_ready && !flush;

    imem_req    = issue_new || (reset && !flush && (state_reg == WAIT_GNT));
    imem_addr   = issue_new ? fetch_pc : (imem_req ? addr_reg : '0);
    pc_take     = issue_new && imem_gnt;
    fetch_stall = ~pc_take;
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = issue_new ? fetch_pc : addr_reg;
    case (state_reg)
      IDLE: begin
        if (issue_new) state_next = imem_gnt ? WAIT_DATA : WAIT_GNT;
      end
      WAIT_GNT: begin
        if (flush)         state_next = imem_gnt ? DISCARD : IDLE;
        else if (imem_gnt) state_next = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (flush)            state_next = imem_rvalid ? IDLE : DISCARD;
        else if (imem_rvalid) begin
          if (issue_new) state_next = imem_gnt ? WAIT_DATA : WAIT_GNT;
          else           state_next = IDLE;
        end
      end
      DISCARD: begin
        if (imem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage holds {instruction, its address}; the write slot is never the head while occupied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entry_mem[i] <= '0;
    end else if (push) begin
      entry_mem[wr_ptr_reg] <= {imem_rdata, addr_reg};
    end
  end

  assign head      = entry_mem[rd_ptr_reg];
  assign dec_valid = (count_reg != '0);
  assign dec_instr = head[AW +: IW];
  assign dec_pc    = head[AW-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: cycle table plus hand-written multi-cycle sequences.
module tb_fetch_queue;

  localparam int AW = 16;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] fetch_pc;
  logic          fetch_stall;
  logic          pc_take;
  logic          flush;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          dec_valid;
  logic          dec_ready;
  logic [IW-1:0] dec_instr;
  logic [AW-1:0] dec_pc;

  fetch_queue #(.DEPTH(4), .AW(AW), .IW(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_pc    (fetch_pc),
    .fetch_stall (fetch_stall),
    .pc_take     (pc_take),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // memory-side stimulus state for the zero-wait sequences
  logic          pend;
  logic [AW-1:0] pend_addr;
  int            grants;
  int            pops;
  logic [AW-1:0] exp_head;

  typedef struct {
    logic [15:0] fpc;
    logic        fl;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        take;
    logic        req;
    logic [15:0] addr;
    logic        dv;
    logic [15:0] dpc;
  } vec_t;

  vec_t tbl [22];

  function automatic logic [31:0] instr(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  function automatic vec_t mk(input logic [15:0] fpc, input logic fl, input logic gnt,
                              input logic rv, input logic [31:0] rdata, input logic rdy,
                              input logic take, input logic req, input logic [15:0] addr,
                              input logic dv, input logic [15:0] dpc);
    vec_t v;
    v.fpc = fpc; v.fl = fl; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
    v.take = take; v.req = req; v.addr = addr; v.dv = dv; v.dpc = dpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold_reset(input int n);
    @(negedge clk);
    reset       = 1'b0;
    flush       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    dec_ready   = 1'b0;
    fetch_pc    = '0;
    for (int i = 0; i < n; i++) @(negedge clk);
    pend = 1'b0; pend_addr = '0; grants = 0; pops = 0;
  endtask

  task automatic drive(input logic [15:0] fpc, input logic fl, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    @(negedge clk);
    reset = 1'b1; fetch_pc = fpc; flush = fl; imem_gnt = gnt;
    imem_rvalid = rv; imem_rdata = rd; dec_ready = rdy;
    #1;
  endtask

  // one cycle against a zero-wait memory; heads are scoreboarded in order
  task automatic mem_cycle(input logic rdy, input logic fl);
    @(negedge clk);
    reset = 1'b1; dec_ready = rdy; flush = fl; imem_gnt = 1'b1;
    imem_rvalid = pend; imem_rdata = instr(pend_addr);
    fetch_pc = 16'h0100 + 16'(grants);
    #1;
    if (rdy && !fl && dec_valid) begin
      check("sb_pc", dec_pc, exp_head);
      check("sb_instr", dec_instr, instr(exp_head));
      exp_head = exp_head + 16'd1;
      pops++;
    end
    if (imem_req) grants++;
    pend      = imem_req;
    pend_addr = imem_addr;
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    tbl[0]  = mk(16'h0000, 0, 1, 0, 32'h0,            1, 1, 1, 16'h0000, 0, 16'h0000);
    tbl[1]  = mk(16'h0001, 0, 1, 1, instr(16'h0000),  1, 1, 1, 16'h0001, 0, 16'h0000);
    tbl[2]  = mk(16'h0002, 0, 1, 1, instr(16'h0001),  1, 1, 1, 16'h0002, 1, 16'h0000);
    tbl[3]  = mk(16'h0003, 0, 1, 1, instr(16'h0002),  1, 1, 1, 16'h0003, 1, 16'h0001);
    tbl[4]  = mk(16'h0004, 0, 0, 1, instr(16'h0003),  1, 0, 1, 16'h0004, 1, 16'h0002);
    tbl[5]  = mk(16'h0009, 0, 0, 0, 32'h0,            1, 0, 1, 16'h0004, 1, 16'h0003);
    tbl[6]  = mk(16'h0009, 0, 1, 0, 32'h0,            1, 0, 1, 16'h0004, 0, 16'h0000);
    tbl[7]  = mk(16'h0005, 0, 0, 1, instr(16'h0004),  1, 0, 1, 16'h0005, 0, 16'h0000);
    tbl[8]  = mk(16'h0005, 1, 0, 0, 32'h0,            1, 0, 0, 16'h0000, 1, 16'h0004);
    tbl[9]  = mk(16'h0040, 0, 1, 0, 32'h0,            1, 1, 1, 16'h0040, 0, 16'h0000);
    tbl[10] = mk(16'h0041, 0, 0, 1, instr(16'h0040),  1, 0, 1, 16'h0041, 0, 16'h0000);
    tbl[11] = mk(16'h0041, 0, 1, 0, 32'h0,            1, 0, 1, 16'h0041, 1, 16'h0040);
    tbl[12] = mk(16'h0042, 1, 1, 1, instr(16'h0041),  1, 0, 0, 16'h0000, 0, 16'h0000);
    tbl[13] = mk(16'h0050, 0, 0, 0, 32'h0,            1, 0, 1, 16'h0050, 0, 16'h0000);
    tbl[14] = mk(16'h0051, 1, 1, 0, 32'h0,            1, 0, 0, 16'h0000, 0, 16'h0000);
    tbl[15] = mk(16'h0060, 0, 1, 0, 32'h0,            1, 0, 0, 16'h0000, 0, 16'h0000);
    tbl[16] = mk(16'h0060, 1, 1, 0, 32'h0,            1, 0, 0, 16'h0000, 0, 16'h0000);
    tbl[17] = mk(16'h0060, 0, 1, 1, 32'hDEADBEEF,     1, 0, 0, 16'h0000, 0, 16'h0000);
    tbl[18] = mk(16'h0060, 0, 1, 0, 32'h0,            1, 1, 1, 16'h0060, 0, 16'h0000);
    tbl[19] = mk(16'h0061, 0, 0, 1, instr(16'h0060),  0, 0, 1, 16'h0061, 0, 16'h0000);
    tbl[20] = mk(16'h0061, 0, 0, 0, 32'h0,            0, 0, 1, 16'h0061, 1, 16'h0060);
    tbl[21] = mk(16'h0077, 0, 0, 0, 32'h0,            0, 0, 1, 16'h0061, 1, 16'h0060);

    // reset held with a noisy memory side
    reset = 1'b0; flush = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
    imem_rdata = 32'h12345678; dec_ready = 1'b1; fetch_pc = 16'h1234;
    pend = 1'b0; pend_addr = '0; grants = 0; pops = 0; exp_head = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      imem_rvalid = i[0];
      #1;
      check("reset_outputs",
            {imem_req, pc_take, fetch_stall, imem_addr, dec_valid, dec_pc, dec_instr},
            {1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 32'h0});
      $display("reset cycle %0d: req=%b stall=%b dv=%b", i, imem_req, fetch_stall, dec_valid);
    end

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].fpc, tbl[i].fl, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy);
      check($sformatf("vec%0d_ctl", i),
            {pc_take, fetch_stall, imem_req, imem_addr, dec_valid},
            {tbl[i].take, ~tbl[i].take, tbl[i].req, tbl[i].addr, tbl[i].dv});
      if (tbl[i].dv)
        check($sformatf("vec%0d_head", i), {dec_pc, dec_instr}, {tbl[i].dpc, instr(tbl[i].dpc)});
      $display("vec %0d: req=%b addr=%h take=%b dv=%b pc=%h", i, imem_req, imem_addr,
               pc_take, dec_valid, dec_pc);
    end

    // grant withheld: address holds, pc_take stays low while waiting
    hold_reset(2);
    drive(16'h0200, 0, 0, 0, 32'h0, 1);
    check("gw_c0", {imem_req, pc_take, imem_addr}, {1'b1, 1'b0, 16'h0200});
    drive(16'h02F0, 0, 0, 0, 32'h0, 1);
    check("gw_c1", {imem_req, pc_take, imem_addr}, {1'b1, 1'b0, 16'h0200});
    drive(16'h02F1, 0, 0, 0, 32'h0, 1);
    check("gw_c2", {imem_req, pc_take, imem_addr}, {1'b1, 1'b0, 16'h0200});
    drive(16'h02F2, 0, 1, 0, 32'h0, 1);
    check("gw_gnt", {imem_req, pc_take, imem_addr}, {1'b1, 1'b0, 16'h0200});
    drive(16'h02F3, 0, 0, 1, instr(16'h0200), 1);
    check("gw_next", {imem_req, pc_take, imem_addr, dec_valid}, {1'b1, 1'b0, 16'h02F3, 1'b0});
    drive(16'h02F3, 0, 0, 0, 32'h0, 1);
    check("gw_head", {dec_valid, dec_pc, dec_instr}, {1'b1, 16'h0200, instr(16'h0200)});
    $display("gnt-wait sequence done");

    // flush while waiting for data; the late response must be dropped
    hold_reset(2);
    drive(16'h0300, 0, 1, 0, 32'h0, 1);
    check("fd_issue", {imem_req, pc_take}, {1'b1, 1'b1});
    drive(16'h0040, 1, 1, 0, 32'h0, 1);
    check("fd_flush", {imem_req, pc_take, fetch_stall}, {1'b0, 1'b0, 1'b1});
    drive(16'h0040, 0, 1, 0, 32'h0, 1);
    check("fd_disc1", {imem_req, pc_take, dec_valid}, {1'b0, 1'b0, 1'b0});
    drive(16'h0040, 0, 1, 1, instr(16'h0300), 1);
    check("fd_disc2", {imem_req, dec_valid}, {1'b0, 1'b0});
    drive(16'h0040, 0, 1, 0, 32'h0, 1);
    check("fd_target", {imem_req, pc_take, imem_addr, dec_valid}, {1'b1, 1'b1, 16'h0040, 1'b0});
    drive(16'h0041, 0, 0, 1, instr(16'h0040), 1);
    check("fd_nodrop", dec_valid, 1'b0);
    drive(16'h0041, 0, 0, 0, 32'h0, 1);
    check("fd_head", {dec_valid, dec_pc, dec_instr}, {1'b1, 16'h0040, instr(16'h0040)});
    $display("flush-during-data sequence done");

    // fill to DEPTH with decode stalled, one pop, then drain across the pointer wrap
    hold_reset(2);
    exp_head = 16'h0100;
    for (int i = 0; i < 8; i++) mem_cycle(1'b0, 1'b0);
    check("full_grants", grants, 4);
    check("full_state", {imem_req, fetch_stall, dec_valid, dec_pc}, {1'b0, 1'b1, 1'b1, 16'h0100});
    mem_cycle(1'b1, 1'b0);
    check("full_pop_noreq", imem_req, 1'b0);
    mem_cycle(1'b0, 1'b0);
    check("full_after_pop", {imem_req, pc_take, imem_addr, dec_pc}, {1'b1, 1'b1, 16'h0104, 16'h0101});
    for (int i = 0; i < 12; i++) mem_cycle(1'b1, 1'b0);
    check("drain_pops", pops, 13);
    check("drain_head", exp_head, 16'h010D);
    $display("full/wrap sequence done: grants=%0d pops=%0d", grants, pops);

    // flush coincident with a pop of a full FIFO
    hold_reset(2);
    for (int i = 0; i < 8; i++) mem_cycle(1'b0, 1'b0);
    check("ff_full", {dec_valid, imem_req}, {1'b1, 1'b0});
    mem_cycle(1'b1, 1'b1);
    check("ff_flush", {imem_req, pc_take}, {1'b0, 1'b0});
    mem_cycle(1'b0, 1'b0);
    check("ff_after", {dec_valid, imem_req, pc_take, imem_addr}, {1'b0, 1'b1, 1'b1, 16'h0104});
    $display("flush-on-full sequence done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
